// File: rtl/clk_divider.sv
// rtl/clk_divider.sv - programmable odd/even integer clock divider with 50% duty outputs
module clk_divider #(
    parameter int WIDTH = 12
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [WIDTH-1:0] clk_divider_odd,
    input  logic [WIDTH-1:0] clk_divider_even,
    output logic             clk_out_odd,
    output logic             clk_out_even
);

    // Even channel state
    logic [WIDTH-1:0] se_q, se_d;   // divisor shadow
    logic [WIDTH-1:0] ce_q, ce_d;   // period counter
    logic             eo_q, eo_d;   // registered output
    logic [WIDTH-1:0] me;           // effective even divisor (LSB forced low)

    // Odd channel state
    logic [WIDTH-1:0] so_q, so_d;   // divisor shadow
    logic [WIDTH-1:0] co_q, co_d;   // period counter
    logic             p_q, p_d;     // posedge phase register
    logic             n_q, n_d;     // negedge copy of p, only used for odd divisors

    // Even channel: count 0..M-1, high while count < M/2; shadow reloads whenever the count returns to 0
    always_comb begin
        se_d = se_q;
        ce_d = '0;
        eo_d = 1'b0;
        me   = {se_q[WIDTH-1:1], 1'b0};
        if (!rst) begin
            se_d = clk_divider_even;
        end else if (me < WIDTH'(2)) begin
            se_d = clk_divider_even;
        end else begin
            eo_d = (ce_q < (se_q >> 1));
            if (ce_q == me - WIDTH'(1)) begin
                ce_d = '0;
                se_d = clk_divider_even;
            end else begin
                ce_d = ce_q + WIDTH'(1);
            end
        end
    end

    // Odd channel: p is high for floor(N/2) cycles; for odd N the negedge copy stretches it by half a cycle
    always_comb begin
        so_d = so_q;
        co_d = '0;
        p_d  = 1'b0;
        if (!rst) begin
            so_d = clk_divider_odd;
        end else if (so_q < WIDTH'(2)) begin
            so_d = clk_divider_odd;
        end else begin
            p_d = (co_q < (so_q >> 1));
            if (co_q == so_q - WIDTH'(1)) begin
                co_d = '0;
                so_d = clk_divider_odd;
            end else begin
                co_d = co_q + WIDTH'(1);
            end
        end
    end

    // Negedge stretch is gated by the shadow parity so even divisors keep exact 50% duty
    always_comb begin
        n_d = p_q & so_q[0];
    end

    // Posedge state registers for both channels
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            se_q <= se_d;
            ce_q <= '0;
            eo_q <= 1'b0;
            so_q <= so_d;
            co_q <= '0;
            p_q  <= 1'b0;
        end else begin
            se_q <= se_d;
            ce_q <= ce_d;
            eo_q <= eo_d;
            so_q <= so_d;
            co_q <= co_d;
            p_q  <= p_d;
        end
    end

    // Negedge register; clears naturally one negedge after p is cleared by reset
    always_ff @(negedge clk_in) begin
        n_q <= n_d;
    end

    assign clk_out_even = eo_q;
    assign clk_out_odd  = p_q | n_q;

endmodule

// File: tb/tb_clk_divider.sv
// tb/tb_clk_divider.sv - scoreboard bench for clk_divider periods, duty and reset behaviour
module tb_clk_divider;

    localparam int WIDTH = 12;
    localparam int GUARD = 20000;

    logic             clk_in;
    logic             rst;
    logic [WIDTH-1:0] clk_divider_odd;
    logic [WIDTH-1:0] clk_divider_even;
    logic             clk_out_odd;
    logic             clk_out_even;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int    hi;
        int    per;
        string tag;
    } exp_t;

    exp_t sb[$];

    clk_divider #(.WIDTH(WIDTH)) dut (
        .clk_in           (clk_in),
        .rst              (rst),
        .clk_divider_odd  (clk_divider_odd),
        .clk_divider_even (clk_divider_even),
        .clk_out_odd      (clk_out_odd),
        .clk_out_even     (clk_out_even)
    );

    initial begin
        clk_in = 1'b0;
        forever #10 clk_in = ~clk_in;
    end

    function automatic bit sample(input bit odd_ch);
        return odd_ch ? clk_out_odd : clk_out_even;
    endfunction

    // Expected high time and period, both in half clk_in cycles
    task automatic push(input int hi, input int per, input string tag);
        exp_t e;
        e.hi  = hi;
        e.per = per;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_bit(input string tag, input bit obs, input bit exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Measures one rise-to-rise period on a grid 5 ns after every clk_in edge.
    // first=1: align and hunt for a rising edge. first=0: caller sits on the first high sample.
    task automatic measure(input bit odd_ch, input bit first);
        exp_t e;
        int   h;
        int   l;
        int   guard;
        bit   prev;
        bit   cur;
        tests++;
        assert (sb.size() > 0) else begin
            fails++;
            $error("FAIL scoreboard_empty observed=%0d expected=>0", sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            guard = 0;
            if (first) begin
                @(posedge clk_in);
                #5;
                prev = sample(odd_ch);
                forever begin
                    #10;
                    cur = sample(odd_ch);
                    guard++;
                    if ((!prev && cur) || guard > GUARD) break;
                    prev = cur;
                end
            end
            h = 1;
            l = 0;
            while (guard <= GUARD) begin
                #10;
                cur = sample(odd_ch);
                guard++;
                if (cur) begin
                    if (l == 0) h++;
                    else break;
                end else begin
                    l++;
                end
            end
            tests++;
            assert (guard <= GUARD) else begin
                fails++;
                $error("FAIL %s_timeout observed=%0d expected<=%0d", e.tag, guard, GUARD);
            end
            tests++;
            assert (h === e.hi) else begin
                fails++;
                $error("FAIL %s_high observed=%0d expected=%0d", e.tag, h, e.hi);
            end
            tests++;
            assert (h + l === e.per) else begin
                fails++;
                $error("FAIL %s_period observed=%0d expected=%0d", e.tag, h + l, e.per);
            end
        end
    endtask

    // Counts high samples of both outputs over a window; a held channel must never go high
    task automatic check_quiet(input string tag, input int cycles);
        int highs;
        highs = 0;
        for (int i = 0; i < 2 * cycles; i++) begin
            #10;
            if (clk_out_odd || clk_out_even) highs++;
        end
        tests++;
        assert (highs === 0) else begin
            fails++;
            $error("FAIL %s observed_high_samples=%0d expected=0", tag, highs);
        end
    endtask

    initial begin
        rst              = 1'b0;
        clk_divider_odd  = 12'd5;
        clk_divider_even = 12'd6;

        // 1: reset, release, rise on first posedge, 5 and 6
        repeat (3) @(negedge clk_in);
        #1;
        check_bit("reset_odd", clk_out_odd, 1'b0);
        check_bit("reset_even", clk_out_even, 1'b0);
        rst = 1'b1;
        @(posedge clk_in);
        #1;
        check_bit("first_rise_odd", clk_out_odd, 1'b1);
        check_bit("first_rise_even", clk_out_even, 1'b1);
        #4;
        push(5, 10, "odd5");
        measure(1'b1, 1'b0);
        push(6, 12, "even6");
        measure(1'b0, 1'b1);

        // 2: divide by 3 and 2
        clk_divider_odd  = 12'd3;
        clk_divider_even = 12'd2;
        push(3, 6, "odd3");
        measure(1'b1, 1'b1);
        push(2, 4, "even2");
        measure(1'b0, 1'b1);

        // 3: divisors of 0 and 1 hold outputs low, then 7 -> 6 and 4
        clk_divider_odd  = 12'd0;
        clk_divider_even = 12'd1;
        repeat (10) @(posedge clk_in);
        #5;
        check_quiet("quiet_o0_e1", 40);
        clk_divider_odd  = 12'd1;
        clk_divider_even = 12'd0;
        repeat (4) @(posedge clk_in);
        #5;
        check_quiet("quiet_o1_e0", 40);
        clk_divider_even = 12'd7;
        push(6, 12, "even7as6");
        measure(1'b0, 1'b1);
        clk_divider_odd = 12'd4;
        push(4, 8, "odd4");
        measure(1'b1, 1'b1);

        // 4: mid-period change 6 -> 10 finishes the current period first
        clk_divider_even = 12'd6;
        push(6, 12, "even6_sync");
        measure(1'b0, 1'b1);
        push(6, 12, "even6_current");
        push(10, 20, "even10_a");
        push(10, 20, "even10_b");
        clk_divider_even = 12'd10;
        measure(1'b0, 1'b0);
        measure(1'b0, 1'b0);
        measure(1'b0, 1'b0);

        // 5: reset mid-period while both channels run
        clk_divider_odd  = 12'd5;
        clk_divider_even = 12'd6;
        push(6, 12, "even6_prereset");
        measure(1'b0, 1'b1);
        rst = 1'b0;
        @(posedge clk_in);
        #1;
        check_bit("midreset_even", clk_out_even, 1'b0);
        @(negedge clk_in);
        #1;
        check_bit("midreset_odd", clk_out_odd, 1'b0);
        repeat (3) @(negedge clk_in);
        #1;
        check_bit("held_reset_odd", clk_out_odd, 1'b0);
        check_bit("held_reset_even", clk_out_even, 1'b0);
        rst = 1'b1;
        @(posedge clk_in);
        #1;
        check_bit("rerise_odd", clk_out_odd, 1'b1);
        check_bit("rerise_even", clk_out_even, 1'b1);
        #4;
        push(6, 12, "even6_postreset");
        measure(1'b0, 1'b0);

        // 6: maximum divisors
        clk_divider_odd  = 12'd4095;
        clk_divider_even = 12'd4094;
        push(4095, 8190, "odd4095");
        measure(1'b1, 1'b1);
        push(4094, 8188, "even4094");
        measure(1'b0, 1'b1);

        tests++;
        assert (sb.size() === 0) else begin
            fails++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
